// File: rtl/axil_arb_2to1.sv
// axil_arb_2to1: two-requester round-robin front end onto a single
// AXI4-Lite master port, one transaction outstanding at a time.
`timescale 1ns/1ps
module axil_arb_2to1 #(
   parameter int ADDR_WIDTH = 4,
   parameter int DATA_WIDTH = 32
) (
   input  logic                    ACLK,
   input  logic                    ARESETN,
   input  logic [1:0]              req,
   input  logic [1:0]              req_we,
   input  logic [2*ADDR_WIDTH-1:0] req_addr,
   input  logic [2*DATA_WIDTH-1:0] req_wdata,
   output logic [1:0]              ack,
   output logic [DATA_WIDTH-1:0]   ack_rdata,
   output logic [1:0]              ack_resp,
   output logic [ADDR_WIDTH-1:0]   M_AXI_AWADDR,
   output logic                    M_AXI_AWVALID,
   input  logic                    M_AXI_AWREADY,
   output logic [DATA_WIDTH-1:0]   M_AXI_WDATA,
   output logic                    M_AXI_WVALID,
   input  logic                    M_AXI_WREADY,
   input  logic [1:0]              M_AXI_BRESP,
   input  logic                    M_AXI_BVALID,
   output logic                    M_AXI_BREADY,
   output logic [ADDR_WIDTH-1:0]   M_AXI_ARADDR,
   output logic                    M_AXI_ARVALID,
   input  logic                    M_AXI_ARREADY,
   input  logic [DATA_WIDTH-1:0]   M_AXI_RDATA,
   input  logic [1:0]              M_AXI_RRESP,
   input  logic                    M_AXI_RVALID,
   output logic                    M_AXI_RREADY
);

   typedef enum logic [2:0] {
      S_IDLE, S_WR, S_WRESP, S_RD_A, S_RD_D
   } state_e;

   state_e                  state_q, state_d;
   logic                    last_q, last_d;
   logic                    gnt_q, gnt_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
   logic                    aw_done_q, aw_done_d;
   logic                    w_done_q, w_done_d;
   logic [1:0]              ack_q, ack_d;
   logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
   logic [1:0]              resp_q, resp_d;

   logic                    gnt_sel;
   logic                    aw_ok;
   logic                    w_ok;

   // On a tie the requester that did not win last time is chosen.
   assign gnt_sel = (req == 2'b11) ? ~last_q : req[1];
   assign aw_ok   = aw_done_q | M_AXI_AWREADY;
   assign w_ok    = w_done_q | M_AXI_WREADY;

   // State and transaction registers; last_q=1 lets requester 0 win first tie.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         state_q   <= S_IDLE;
         last_q    <= 1'b1;
         gnt_q     <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         aw_done_q <= 1'b0;
         w_done_q  <= 1'b0;
         ack_q     <= '0;
         rdata_q   <= '0;
         resp_q    <= '0;
      end else begin
         state_q   <= state_d;
         last_q    <= last_d;
         gnt_q     <= gnt_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         aw_done_q <= aw_done_d;
         w_done_q  <= w_done_d;
         ack_q     <= ack_d;
         rdata_q   <= rdata_d;
         resp_q    <= resp_d;
      end
   end

   // Next-state: grant, channel handshake tracking and completion capture.
   always_comb begin
      state_d   = state_q;
      last_d    = last_q;
      gnt_d     = gnt_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      aw_done_d = aw_done_q;
      w_done_d  = w_done_q;
      ack_d     = '0;
      rdata_d   = rdata_q;
      resp_d    = resp_q;
      unique case (state_q)
         S_IDLE: begin
            if (|req) begin
               gnt_d     = gnt_sel;
               last_d    = gnt_sel;
               addr_d    = gnt_sel ? req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH]
                                   : req_addr[ADDR_WIDTH-1:0];
               wdata_d   = gnt_sel ? req_wdata[2*DATA_WIDTH-1:DATA_WIDTH]
                                   : req_wdata[DATA_WIDTH-1:0];
               aw_done_d = 1'b0;
               w_done_d  = 1'b0;
               state_d   = req_we[gnt_sel] ? S_WR : S_RD_A;
            end
         end
         S_WR: begin
            aw_done_d = aw_ok;
            w_done_d  = w_ok;
            if (aw_ok && w_ok) state_d = S_WRESP;
         end
         S_WRESP: begin
            if (M_AXI_BVALID) begin
               ack_d[gnt_q] = 1'b1;
               rdata_d      = '0;
               resp_d       = M_AXI_BRESP;
               state_d      = S_IDLE;
            end
         end
         S_RD_A: begin
            if (M_AXI_ARREADY) state_d = S_RD_D;
         end
         S_RD_D: begin
            if (M_AXI_RVALID) begin
               ack_d[gnt_q] = 1'b1;
               rdata_d      = M_AXI_RDATA;
               resp_d       = M_AXI_RRESP;
               state_d      = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Channel VALID/READY decode from the current state.
   always_comb begin
      M_AXI_AWVALID = 1'b0;
      M_AXI_WVALID  = 1'b0;
      M_AXI_BREADY  = 1'b0;
      M_AXI_ARVALID = 1'b0;
      M_AXI_RREADY  = 1'b0;
      unique case (state_q)
         S_WR: begin
            M_AXI_AWVALID = ~aw_done_q;
            M_AXI_WVALID  = ~w_done_q;
         end
         S_WRESP: M_AXI_BREADY  = 1'b1;
         S_RD_A:  M_AXI_ARVALID = 1'b1;
         S_RD_D:  M_AXI_RREADY  = 1'b1;
         default: ;
      endcase
   end

   assign M_AXI_AWADDR = addr_q;
   assign M_AXI_ARADDR = addr_q;
   assign M_AXI_WDATA  = wdata_q;
   assign ack          = ack_q;
   assign ack_rdata    = rdata_q;
   assign ack_resp     = resp_q;

endmodule

// File: tb/tb_axil_arb_2to1.sv
// tb_axil_arb_2to1: randomized checks of the 2:1 AXI4-Lite arbiter
// against a transaction-level arbitration and memory model.
`timescale 1ns/1ps
module tb_axil_arb_2to1;

   logic        ACLK = 1'b0;
   logic        ARESETN = 1'b1;
   logic [1:0]  req, req_we;
   logic [7:0]  req_addr;
   logic [63:0] req_wdata;
   logic [1:0]  ack;
   logic [31:0] ack_rdata;
   logic [1:0]  ack_resp;
   logic [3:0]  M_AXI_AWADDR, M_AXI_ARADDR;
   logic        M_AXI_AWVALID, M_AXI_AWREADY;
   logic [31:0] M_AXI_WDATA, M_AXI_RDATA;
   logic        M_AXI_WVALID, M_AXI_WREADY;
   logic [1:0]  M_AXI_BRESP, M_AXI_RRESP;
   logic        M_AXI_BVALID, M_AXI_BREADY;
   logic        M_AXI_ARVALID, M_AXI_ARREADY;
   logic        M_AXI_RVALID, M_AXI_RREADY;

   always #5 ACLK = ~ACLK;

   axil_arb_2to1 #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) dut (
      .ACLK(ACLK), .ARESETN(ARESETN),
      .req(req), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .ack(ack), .ack_rdata(ack_rdata), .ack_resp(ack_resp),
      .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWVALID(M_AXI_AWVALID),
      .M_AXI_AWREADY(M_AXI_AWREADY),
      .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WVALID(M_AXI_WVALID),
      .M_AXI_WREADY(M_AXI_WREADY),
      .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID),
      .M_AXI_BREADY(M_AXI_BREADY),
      .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARVALID(M_AXI_ARVALID),
      .M_AXI_ARREADY(M_AXI_ARREADY),
      .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
      .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY)
   );

   // ---------------- slave memory with programmable latency
   int aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
   logic [1:0] bresp_cfg = 2'b00, rresp_cfg = 2'b00;
   int aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
   logic aw_got, w_got, b_pend, r_pend;
   logic [3:0]  s_awaddr;
   logic [31:0] s_wdata, s_rdata;
   logic [31:0] s_mem [4];

   wire aw_hs_w = M_AXI_AWVALID && M_AXI_AWREADY;
   wire w_hs_w  = M_AXI_WVALID && M_AXI_WREADY;
   wire ar_hs_w = M_AXI_ARVALID && M_AXI_ARREADY;
   wire got_a   = aw_got || aw_hs_w;
   wire got_d   = w_got || w_hs_w;
   wire [3:0]  wa = aw_got ? s_awaddr : M_AXI_AWADDR;
   wire [31:0] wd = w_got ? s_wdata : M_AXI_WDATA;

   assign M_AXI_AWREADY = M_AXI_AWVALID && (aw_cnt >= aw_dly);
   assign M_AXI_WREADY  = M_AXI_WVALID && (w_cnt >= w_dly);
   assign M_AXI_ARREADY = M_AXI_ARVALID && (ar_cnt >= ar_dly);
   assign M_AXI_BVALID  = b_pend && (b_cnt >= b_dly);
   assign M_AXI_RVALID  = r_pend && (r_cnt >= r_dly);
   assign M_AXI_BRESP   = bresp_cfg;
   assign M_AXI_RRESP   = rresp_cfg;
   assign M_AXI_RDATA   = s_rdata;

   always @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0;
         b_cnt <= 0; r_cnt <= 0;
         aw_got <= 0; w_got <= 0;
         b_pend <= 0; r_pend <= 0;
         s_awaddr <= '0; s_wdata <= '0; s_rdata <= '0;
         for (int i = 0; i < 4; i++) s_mem[i] <= '0;
      end else begin
         aw_cnt <= (aw_hs_w || !M_AXI_AWVALID) ? 0 : aw_cnt + 1;
         w_cnt  <= (w_hs_w || !M_AXI_WVALID) ? 0 : w_cnt + 1;
         ar_cnt <= (ar_hs_w || !M_AXI_ARVALID) ? 0 : ar_cnt + 1;
         if (got_a && got_d) begin
            s_mem[wa[3:2]] <= wd;
            aw_got <= 0; w_got <= 0;
            b_pend <= 1; b_cnt <= 0;
         end else begin
            aw_got <= got_a; w_got <= got_d;
            if (aw_hs_w) s_awaddr <= M_AXI_AWADDR;
            if (w_hs_w) s_wdata <= M_AXI_WDATA;
         end
         if (b_pend) begin
            if (M_AXI_BVALID && M_AXI_BREADY) b_pend <= 0;
            else b_cnt <= b_cnt + 1;
         end
         if (ar_hs_w) begin
            r_pend <= 1; r_cnt <= 0;
            s_rdata <= s_mem[M_AXI_ARADDR[3:2]];
         end else if (r_pend) begin
            if (M_AXI_RVALID && M_AXI_RREADY) r_pend <= 0;
            else r_cnt <= r_cnt + 1;
         end
      end
   end

   // ---------------- channel monitor (stability, handshake counts)
   int prot_err = 0, aw_hs = 0, w_hs = 0, b_rise = 0;
   logic aw_hold = 0, w_hold = 0, ar_hold = 0, bready_prev = 0;
   logic [3:0]  aw_hold_a, ar_hold_a;
   logic [31:0] w_hold_d;

   always @(negedge ACLK) begin
      if (!ARESETN) begin
         aw_hold <= 0; w_hold <= 0; ar_hold <= 0; bready_prev <= 0;
      end else begin
         prot_err <= prot_err
           + int'(aw_hold && !(M_AXI_AWVALID && M_AXI_AWADDR == aw_hold_a))
           + int'(w_hold && !(M_AXI_WVALID && M_AXI_WDATA == w_hold_d))
           + int'(ar_hold && !(M_AXI_ARVALID && M_AXI_ARADDR == ar_hold_a));
         aw_hold   <= M_AXI_AWVALID && !M_AXI_AWREADY;
         w_hold    <= M_AXI_WVALID && !M_AXI_WREADY;
         ar_hold   <= M_AXI_ARVALID && !M_AXI_ARREADY;
         aw_hold_a <= M_AXI_AWADDR;
         w_hold_d  <= M_AXI_WDATA;
         ar_hold_a <= M_AXI_ARADDR;
         aw_hs     <= aw_hs + int'(aw_hs_w);
         w_hs      <= w_hs + int'(w_hs_w);
         b_rise    <= b_rise + int'(M_AXI_BREADY && !bready_prev);
         bready_prev <= M_AXI_BREADY;
      end
   end

   // ---------------- reference model
   typedef struct {
      bit          we;
      logic [3:0]  addr;
      logic [31:0] data;
   } cmd_t;

   cmd_t        q0[$], q1[$];
   int          exp_n[$], obs_n[$];
   logic [31:0] exp_rd[$], obs_rd[$];
   logic [1:0]  exp_rs[$], obs_rs[$];
   logic [31:0] model_mem [4];
   int          m_tie;
   int          checks = 0, failures = 0;

   function automatic cmd_t mk(bit we, int a, logic [31:0] d);
      cmd_t c;
      c.we = we; c.addr = 4'(a); c.data = d;
      return c;
   endfunction

   function automatic cmd_t rnd_cmd();
      return mk(1'($urandom_range(0, 1)), 4 * $urandom_range(0, 3),
                $urandom);
   endfunction

   // Expected completion order: every queued requester keeps req high,
   // so a grant sees both pending until one queue empties.
   function automatic void predict();
      int i0 = 0, i1 = 0, w;
      cmd_t c;
      exp_n.delete(); exp_rd.delete(); exp_rs.delete();
      while (i0 < q0.size() || i1 < q1.size()) begin
         if (i0 < q0.size() && i1 < q1.size()) w = m_tie;
         else w = (i1 < q1.size()) ? 1 : 0;
         m_tie = 1 - w;
         if (w == 0) begin c = q0[i0]; i0++; end
         else begin c = q1[i1]; i1++; end
         exp_n.push_back(w);
         if (c.we) begin
            model_mem[c.addr[3:2]] = c.data;
            exp_rd.push_back(32'h0);
            exp_rs.push_back(bresp_cfg);
         end else begin
            exp_rd.push_back(model_mem[c.addr[3:2]]);
            exp_rs.push_back(rresp_cfg);
         end
      end
   endfunction

   task automatic drive(input int i0, input int i1);
      req = 2'b00; req_we = 2'b00;
      req_addr = '0; req_wdata = '0;
      if (i0 < q0.size()) begin
         req[0] = 1; req_we[0] = q0[i0].we;
         req_addr[3:0] = q0[i0].addr; req_wdata[31:0] = q0[i0].data;
      end
      if (i1 < q1.size()) begin
         req[1] = 1; req_we[1] = q1[i1].we;
         req_addr[7:4] = q1[i1].addr; req_wdata[63:32] = q1[i1].data;
      end
   endtask

   // Requester side: present queue heads, pop on ack, record every ack.
   task automatic run_cmds(output bit tmo);
      int i0 = 0, i1 = 0, cyc = 0;
      obs_n.delete(); obs_rd.delete(); obs_rs.delete();
      tmo = 0;
      drive(i0, i1);
      while ((i0 < q0.size() || i1 < q1.size()) && !tmo) begin
         @(negedge ACLK);
         cyc++;
         for (int n = 0; n < 2; n++)
            if (ack[n]) begin
               obs_n.push_back(n); obs_rd.push_back(ack_rdata);
               obs_rs.push_back(ack_resp);
            end
         if (ack[0]) i0++;
         if (ack[1]) i1++;
         drive(i0, i1);
         if (cyc > 2000) tmo = 1;
      end
      req = 2'b00;
      repeat (6) begin
         @(negedge ACLK);
         for (int n = 0; n < 2; n++)
            if (ack[n]) begin
               obs_n.push_back(n); obs_rd.push_back(ack_rdata);
               obs_rs.push_back(ack_resp);
            end
      end
   endtask

   task automatic apply_reset();
      @(negedge ACLK);
      ARESETN = 0; req = 0;
      repeat (3) @(negedge ACLK);
      ARESETN = 1;
      m_tie = 0;
      for (int i = 0; i < 4; i++) model_mem[i] = '0;
      @(negedge ACLK);
   endtask

   // ---------------- tests
   task automatic test_reset();
      logic [4:0] vr;
      req = 0; req_we = 0; req_addr = 0; req_wdata = 0;
      @(negedge ACLK);
      ARESETN = 0;
      #1;
      vr = {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY,
            M_AXI_ARVALID, M_AXI_RREADY};
      checks++;
      if (vr !== 5'b0) begin
         failures++; $display("FAIL reset_valid: got %b want 00000", vr);
      end
      checks++;
      if ({ack, ack_rdata, ack_resp} !== 36'h0) begin
         failures++;
         $display("FAIL reset_ack: ack=%b rdata=%h resp=%b want 0",
                  ack, ack_rdata, ack_resp);
      end
      checks++;
      if ({M_AXI_AWADDR, M_AXI_ARADDR, M_AXI_WDATA} !== 40'h0) begin
         failures++;
         $display("FAIL reset_addr: aw=%h ar=%h wd=%h want 0",
                  M_AXI_AWADDR, M_AXI_ARADDR, M_AXI_WDATA);
      end
      repeat (2) @(negedge ACLK);
      ARESETN = 1;
      m_tie = 0;
      for (int i = 0; i < 4; i++) model_mem[i] = '0;
      repeat (2) @(negedge ACLK);
      vr = {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY,
            M_AXI_ARVALID, M_AXI_RREADY};
      checks++;
      if (vr !== 5'b0 || ack !== 2'b0) begin
         failures++;
         $display("FAIL reset_idle: valid=%b ack=%b want 0", vr, ack);
      end
   endtask

   task automatic test_wr_rd_seq();
      bit tmo;
      q0.delete(); q1.delete();
      for (int i = 0; i < 4; i++) q0.push_back(mk(1, 4 * i, 32'(i + 1)));
      for (int i = 0; i < 4; i++) q0.push_back(mk(0, 4 * i, 32'h0));
      bresp_cfg = 0; rresp_cfg = 0;
      aw_dly = $urandom_range(0, 2); w_dly = $urandom_range(0, 2);
      b_dly = $urandom_range(0, 2); ar_dly = $urandom_range(0, 2);
      r_dly = $urandom_range(0, 2);
      predict();
      run_cmds(tmo);
      checks++;
      if (tmo || obs_n.size() != 8) begin
         failures++;
         $display("FAIL seq_count: got %0d acks tmo=%0d want 8",
                  obs_n.size(), tmo);
      end
      for (int k = 0; k < 8 && k < obs_n.size(); k++) begin
         checks++;
         if (obs_n[k] !== exp_n[k] || obs_rd[k] !== exp_rd[k] ||
             obs_rs[k] !== exp_rs[k]) begin
            failures++;
            $display("FAIL seq_ack%0d: got r%0d %h %b want r%0d %h %b", k,
                     obs_n[k], obs_rd[k], obs_rs[k],
                     exp_n[k], exp_rd[k], exp_rs[k]);
         end
      end
   endtask

   task automatic test_tie();
      bit tmo;
      apply_reset();
      q0.delete(); q1.delete();
      q0.push_back(mk(1, 0, 32'hA5A5A5A5));
      q0.push_back(mk(0, 0, 32'h0));
      q1.push_back(mk(0, 0, 32'h0));
      predict();
      run_cmds(tmo);
      checks++;
      if (tmo || obs_n.size() != exp_n.size()) begin
         failures++;
         $display("FAIL tie_count: got %0d acks tmo=%0d want %0d",
                  obs_n.size(), tmo, exp_n.size());
      end
      for (int k = 0; k < exp_n.size() && k < obs_n.size(); k++) begin
         checks++;
         if (obs_n[k] !== exp_n[k] || obs_rd[k] !== exp_rd[k] ||
             obs_rs[k] !== exp_rs[k]) begin
            failures++;
            $display("FAIL tie_ack%0d: got r%0d %h %b want r%0d %h %b", k,
                     obs_n[k], obs_rd[k], obs_rs[k],
                     exp_n[k], exp_rd[k], exp_rs[k]);
         end
      end
   endtask

   task automatic test_write_timing();
      bit tmo;
      int bb, ba, bw;
      int aws[3] = '{3, 0, 0};
      int wss[3] = '{0, 0, 3};
      for (int c = 0; c < 3; c++) begin
         aw_dly = aws[c]; w_dly = wss[c]; b_dly = c;
         q0.delete(); q1.delete();
         q0.push_back(mk(1, 4 * $urandom_range(0, 3), $urandom));
         predict();
         bb = b_rise; ba = aw_hs; bw = w_hs;
         run_cmds(tmo);
         checks++;
         if (tmo || b_rise - bb != 1) begin
            failures++;
            $display("FAIL wtime%0d_bready: got %0d phases want 1",
                     c, b_rise - bb);
         end
         checks++;
         if (aw_hs - ba != 1 || w_hs - bw != 1) begin
            failures++;
            $display("FAIL wtime%0d_hs: got aw=%0d w=%0d want 1/1",
                     c, aw_hs - ba, w_hs - bw);
         end
         checks++;
         if (obs_n.size() != 1 || obs_n[0] !== exp_n[0] ||
             obs_rs[0] !== exp_rs[0] || obs_rd[0] !== exp_rd[0]) begin
            failures++;
            $display("FAIL wtime%0d_ack: got %0d acks want 1", c,
                     obs_n.size());
         end
      end
      aw_dly = 0; w_dly = 0; b_dly = 0;
   endtask

   task automatic test_bresp_err();
      bit tmo;
      int ba;
      bresp_cfg = 2'b10;
      q0.delete(); q1.delete();
      q1.push_back(mk(1, 4, $urandom));
      predict();
      ba = aw_hs;
      run_cmds(tmo);
      checks++;
      if (tmo || obs_n.size() != 1 || obs_rs[0] !== 2'b10 ||
          obs_n[0] !== exp_n[0]) begin
         failures++;
         $display("FAIL berr_ack: got %0d acks resp=%b want 1 resp=10",
                  obs_n.size(), ack_resp);
      end
      checks++;
      if (aw_hs - ba != 1 || M_AXI_AWVALID !== 0 || M_AXI_BREADY !== 0)
      begin
         failures++;
         $display("FAIL berr_reissue: got aw_hs=%0d awv=%b br=%b want 1 0 0",
                  aw_hs - ba, M_AXI_AWVALID, M_AXI_BREADY);
      end
      bresp_cfg = 2'b00;
   endtask

   task automatic test_reset_mid();
      bit tmo;
      bit seen = 0;
      logic [4:0] vr;
      r_dly = 30;
      @(negedge ACLK);
      req = 2'b01; req_we = 2'b00; req_addr = 8'h08;
      for (int i = 0; i < 50 && !seen; i++) begin
         @(negedge ACLK);
         seen = M_AXI_RREADY;
      end
      req = 2'b00;
      checks++;
      if (!seen) begin
         failures++; $display("FAIL rmid_rready: got 0 want 1");
      end
      repeat (2) @(negedge ACLK);
      #2 ARESETN = 0;
      #1;
      vr = {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY,
            M_AXI_ARVALID, M_AXI_RREADY};
      checks++;
      if (vr !== 5'b0 || {ack, ack_rdata, ack_resp} !== 36'h0 ||
          {M_AXI_AWADDR, M_AXI_ARADDR, M_AXI_WDATA} !== 40'h0) begin
         failures++;
         $display("FAIL rmid_outs: valid=%b ack=%b rd=%h ar=%h want 0",
                  vr, ack, ack_rdata, M_AXI_ARADDR);
      end
      for (int i = 0; i < 3; i++) begin
         @(negedge ACLK);
         checks++;
         if (ack !== 2'b0) begin
            failures++; $display("FAIL rmid_noack: got %b want 00", ack);
         end
      end
      ARESETN = 1;
      r_dly = 1;
      m_tie = 0;
      for (int i = 0; i < 4; i++) model_mem[i] = '0;
      @(negedge ACLK);
      q0.delete(); q1.delete();
      q0.push_back(mk(1, 4, $urandom));
      q0.push_back(mk(0, 4, 32'h0));
      q0.push_back(mk(0, 8, 32'h0));
      predict();
      run_cmds(tmo);
      checks++;
      if (tmo || obs_n.size() != exp_n.size()) begin
         failures++;
         $display("FAIL rmid_count: got %0d acks want %0d",
                  obs_n.size(), exp_n.size());
      end
      for (int k = 0; k < exp_n.size() && k < obs_n.size(); k++) begin
         checks++;
         if (obs_n[k] !== exp_n[k] || obs_rd[k] !== exp_rd[k] ||
             obs_rs[k] !== exp_rs[k]) begin
            failures++;
            $display("FAIL rmid_ack%0d: got r%0d %h %b want r%0d %h %b", k,
                     obs_n[k], obs_rd[k], obs_rs[k],
                     exp_n[k], exp_rd[k], exp_rs[k]);
         end
      end
   endtask

   task automatic test_alternate();
      bit tmo;
      int c0 = 0, c1 = 0;
      apply_reset();
      q0.delete(); q1.delete();
      for (int i = 0; i < 4; i++) begin
         q0.push_back(rnd_cmd());
         q1.push_back(rnd_cmd());
      end
      predict();
      run_cmds(tmo);
      for (int k = 0; k < obs_n.size(); k++) begin
         if (obs_n[k] == 0) c0++; else c1++;
      end
      checks++;
      if (tmo || c0 != 4 || c1 != 4) begin
         failures++;
         $display("FAIL alt_count: got r0=%0d r1=%0d want 4/4", c0, c1);
      end
      for (int k = 0; k < 8 && k < obs_n.size(); k++) begin
         checks++;
         if (obs_n[k] !== k % 2 || obs_rd[k] !== exp_rd[k] ||
             obs_rs[k] !== exp_rs[k]) begin
            failures++;
            $display("FAIL alt_ack%0d: got r%0d %h %b want r%0d %h %b", k,
                     obs_n[k], obs_rd[k], obs_rs[k],
                     k % 2, exp_rd[k], exp_rs[k]);
         end
      end
   endtask

   task automatic test_random();
      bit tmo;
      for (int r = 0; r < 8; r++) begin
         aw_dly = $urandom_range(0, 3); w_dly = $urandom_range(0, 3);
         b_dly = $urandom_range(0, 3); ar_dly = $urandom_range(0, 3);
         r_dly = $urandom_range(0, 3);
         bresp_cfg = 2'($urandom_range(0, 3));
         rresp_cfg = 2'($urandom_range(0, 3));
         q0.delete(); q1.delete();
         repeat ($urandom_range(0, 5)) q0.push_back(rnd_cmd());
         repeat ($urandom_range(1, 5)) q1.push_back(rnd_cmd());
         predict();
         run_cmds(tmo);
         checks++;
         if (tmo || obs_n.size() != exp_n.size()) begin
            failures++;
            $display("FAIL rnd%0d_count: got %0d acks want %0d", r,
                     obs_n.size(), exp_n.size());
         end
         for (int k = 0; k < exp_n.size() && k < obs_n.size(); k++) begin
            checks++;
            if (obs_n[k] !== exp_n[k] || obs_rd[k] !== exp_rd[k] ||
                obs_rs[k] !== exp_rs[k]) begin
               failures++;
               $display("FAIL rnd%0d_ack%0d: got r%0d %h %b want r%0d %h %b",
                        r, k, obs_n[k], obs_rd[k], obs_rs[k],
                        exp_n[k], exp_rd[k], exp_rs[k]);
            end
         end
      end
      bresp_cfg = 0; rresp_cfg = 0;
   endtask

   task automatic test_protocol();
      checks++;
      if (prot_err != 0) begin
         failures++;
         $display("FAIL chan_stable: got %0d violations want 0", prot_err);
      end
   endtask

   initial begin
      req = 0; req_we = 0; req_addr = 0; req_wdata = 0;
      m_tie = 0;
      for (int i = 0; i < 4; i++) model_mem[i] = '0;
      test_reset();
      test_wr_rd_seq();
      test_tie();
      test_write_timing();
      test_bresp_err();
      test_reset_mid();
      test_alternate();
      test_random();
      test_protocol();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/axil_arb_2to1.md
AXIL_ARB_2TO1 -- requirements
Module: axil_arb_2to1

Interface
REQ-001 ADDR_WIDTH, 4, AXI4-Lite byte address width (4 registers × 4 bytes).
REQ-002 DATA_WIDTH, 32, AXI4-Lite data width; only 32 is supported.
REQ-003 ACLK  in  1  single clock; all logic is rising-edge.
REQ-004 ARESETN  in  1  asynchronous active-low reset.
REQ-005 req  in  2  per-requester transaction request, bit n = requester n.
REQ-006 req_we  in  2  per-requester direction: 1 = write, 0 = read.
REQ-007 req_addr  in  2*ADDR_WIDTH  per-requester address; requester n uses slice n.
REQ-008 req_wdata  in  2*DATA_WIDTH  per-requester write data; requester n uses slice n.
REQ-009 ack  out  2  one-cycle completion pulse, bit n = requester n.
REQ-010 ack_rdata  out  DATA_WIDTH  read data; valid while any ack bit is high.
REQ-011 ack_resp  out  2  BRESP/RRESP of the completed transaction; valid with ack.
REQ-012 M_AXI_AWADDR/AWVALID  out  ADDR_WIDTH/1  write address channel; AWREADY  in  1.
REQ-013 M_AXI_WDATA/WVALID  out  DATA_WIDTH/1  write data channel; WREADY  in  1.
REQ-014 M_AXI_BRESP  in  2, M_AXI_BVALID  in  1, M_AXI_BREADY  out  1  write response channel.
REQ-015 M_AXI_ARADDR/ARVALID  out  ADDR_WIDTH/1  read address channel; ARREADY  in  1.
REQ-016 M_AXI_RDATA  in  DATA_WIDTH, RRESP  in  2, RVALID  in  1, RREADY  out  1  read data channel.
REQ-017 The block has no PROT/STRB ports; integration ties slave AWPROT/ARPROT to 0 and WSTRB to all-ones.

Function
REQ-018 FSM states: IDLE, WR, WRESP, RD_A, RD_D; at most one AXI transaction is outstanding.
REQ-019 IDLE: if any req bit is high at a rising edge, the block grants one requester and latches its we/addr/wdata; it enters WR (we=1) or RD_A (we=0).
REQ-020 Arbitration is round-robin with a 1-bit last-grant pointer: a lone requester wins; if both request, the requester not granted last wins; after reset requester 0 wins the first tie.
REQ-021 WR: AWVALID and WVALID rise in the cycle after the grant; each drops independently on its own handshake (AWREADY, WREADY); WRESP is entered once both handshakes are complete, including when both occur in the same cycle.
REQ-022 WRESP: BREADY=1; on BVALID the block latches BRESP and returns to IDLE.
REQ-023 RD_A: ARVALID=1 until ARREADY; then RD_D.
REQ-024 RD_D: RREADY=1; on RVALID the block latches RDATA/RRESP and returns to IDLE.
REQ-025 ack[grantee] pulses for exactly one cycle, registered, in the cycle after the B or R handshake; ack_rdata/ack_resp are stable from that cycle until the next completion. ack_rdata is 0 after a write.
REQ-026 The block may grant again in the same cycle its ack is high; the requester must deassert req in the ack cycle, otherwise the held req is treated as a new request.
REQ-027 The block ignores req deassertion after grant; the transaction completes and ack still pulses.
REQ-028 Error responses (SLVERR/DECERR) are passed through unchanged on ack_resp and cause no retry.
REQ-029 AXI outputs hold stable while VALID is high and READY is low; addr/data are never modified mid-transaction.

Reset
REQ-030 ARESETN low asynchronously forces: state IDLE, all VALID/READY outputs 0, ack 0, ack_rdata 0, ack_resp 0, AWADDR/ARADDR/WDATA 0, last-grant pointer set so requester 0 wins the next tie.
REQ-031 Reset mid-transaction abandons that transaction without ack; the slave is reset by the same ARESETN.

Verification
REQ-032 Requester 0 writes 0x00000001..0x00000004 to addr 0x0,0x4,0x8,0xC, then reads them back -> reads return the written data, ack_resp=0 on all eight transactions.
REQ-033 Both requesters request in the same cycle after reset (r0 write 0xA5A5A5A5 @0x0, r1 read @0x0) -> r0 is granted first; r1 reads 0xA5A5A5A5; r1 wins the next tie.
REQ-034 Write with AWREADY delayed 3 cycles and WREADY immediate, and again with both readies in the same cycle -> the single BREADY phase in each case, with ack pulsing exactly once.
REQ-035 Slave returns BRESP=2'b10 -> ack_resp=2'b10 with ack, FSM back in IDLE, no reissue.
REQ-036 ARESETN pulled low while in RD_D with RVALID low -> all outputs 0 immediately, no ack; after release the next request completes normally.
REQ-037 Both req held high continuously for 8 transactions -> grants alternate 0,1,0,1,..., with exactly 4 acks per requester.
